// File: rtl/vdma_baseaddr_pkg.sv
// Shared types and helpers for the VDMA frame-buffer pointer arbiter.
// Optional statistics are enabled with the VDMA_BASEADDR_STAT_EN macro (see top).
package vdma_baseaddr_pkg;

    // Arbiter control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    // First index in cur+1, cur+2 (mod num_buf) that differs from avoid.
    // With num_buf >= 3 two candidates are always enough, since only one
    // index has to be avoided.
    function automatic int next_free(input int cur, input int avoid, input int num_buf);
        int c1;
        int c2;
        c1 = (cur == num_buf - 1) ? 0 : cur + 1;
        c2 = (c1 == num_buf - 1) ? 0 : c1 + 1;
        return (c1 != avoid) ? c1 : c2;
    endfunction

endpackage

// File: rtl/vdma_vs_edge.sv
// Rising-edge detector for a vertical-sync level. The history register is
// always tracking, so an edge is reported only for a genuine 0->1 step.
module vdma_vs_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vs,
    output logic o_rise
);

    logic r_vs_d;

    // Previous-cycle copy of the sync level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_vs_d <= 1'b0;
        else        r_vs_d <= i_vs;
    end

    assign o_rise = i_vs & ~r_vs_d;

endmodule

// File: rtl/vdma_baseaddr_arbiter.sv
// Frame-buffer pointer arbiter for one write VDMA / read VDMA pair.
// The writer steps to a free buffer on each write vsync, the reader jumps to
// the latest completed frame on each read vsync, and the writer never lands
// on the buffer being read.
// Build option: define VDMA_BASEADDR_STAT_EN to add drop/repeat counters
// (and the CNT_W parameter that sizes them).
module vdma_baseaddr_arbiter
    import vdma_baseaddr_pkg::*;
#(
    parameter int NUM_BUF = 3,
    parameter int PTR_W   = 3
`ifdef VDMA_BASEADDR_STAT_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             wr_vs,
    input  logic             rd_vs,
    output logic [PTR_W-1:0] wr_point,
    output logic [PTR_W-1:0] rd_point,
    output logic             frame_fresh,
    output logic             run
`ifdef VDMA_BASEADDR_STAT_EN
    ,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] repeat_cnt
`endif
);

    // Bit 0 = write side, bit 1 = read side
    logic [1:0] w_vs;
    logic [1:0] w_rise;
    logic       w_wr_e;
    logic       w_rd_e;

    assign w_vs = {rd_vs, wr_vs};

    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
        vdma_vs_edge u_edge (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_vs   (w_vs[gi]),
            .o_rise (w_rise[gi])
        );
    end

    assign w_wr_e = w_rise[0];
    assign w_rd_e = w_rise[1];

    state_t r_state;
    state_t w_state_next;
    logic   w_run;
    logic   w_step;

    logic [PTR_W-1:0] r_wr_point;
    logic [PTR_W-1:0] r_rd_point;
    logic [PTR_W-1:0] r_latest;
    logic             r_fresh;
    logic [PTR_W-1:0] w_wr_nf;
    logic [PTR_W-1:0] w_wr_inc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state: enable arms the arbiter, the first write vsync starts it
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (enable) w_state_next = PRIME;
            PRIME:   if (!enable) w_state_next = IDLE;
                     else if (w_wr_e) w_state_next = RUN;
            RUN:     if (!enable) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State-derived controls: pointers only move while running and enabled
    always_comb begin
        w_run  = (r_state == RUN);
        w_step = (r_state == RUN) && enable;
    end

    // Candidate write pointers: skip the reader, or plain increment when the
    // reader is moving onto the current write buffer in the same cycle
    assign w_wr_nf  = PTR_W'(next_free(int'(r_wr_point), int'(r_rd_point), NUM_BUF));
    assign w_wr_inc = PTR_W'(next_free(int'(r_wr_point), int'(r_wr_point), NUM_BUF));

    // Pointer/freshness update; the write side is resolved before the read side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_point <= '0;
            r_rd_point <= PTR_W'(1);
            r_latest   <= PTR_W'(1);
            r_fresh    <= 1'b0;
        end else if (w_run && !enable) begin
            r_fresh <= 1'b0;
        end else if (w_step) begin
            case ({w_wr_e, w_rd_e})
                2'b11: begin
                    r_rd_point <= r_wr_point;
                    r_latest   <= r_wr_point;
                    r_wr_point <= w_wr_inc;
                    r_fresh    <= 1'b0;
                end
                2'b10: begin
                    r_latest   <= r_wr_point;
                    r_wr_point <= w_wr_nf;
                    r_fresh    <= 1'b1;
                end
                2'b01: begin
                    if (r_fresh) begin
                        r_rd_point <= r_latest;
                        r_fresh    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_point    = r_wr_point;
    assign rd_point    = r_rd_point;
    assign frame_fresh = r_fresh;
    assign run         = w_run;

`ifdef VDMA_BASEADDR_STAT_EN
    logic             r_enable_d;
    logic             w_en_rise;
    logic             w_drop;
    logic             w_repeat;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_repeat_cnt;

    assign w_en_rise = enable & ~r_enable_d;
    assign w_drop    = w_step &  w_wr_e & ~w_rd_e &  r_fresh;
    assign w_repeat  = w_step & ~w_wr_e &  w_rd_e & ~r_fresh;

    // Saturating statistics, restarted on each enable rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable_d   <= 1'b0;
            r_drop_cnt   <= '0;
            r_repeat_cnt <= '0;
        end else begin
            r_enable_d <= enable;
            if (w_en_rise) begin
                r_drop_cnt   <= '0;
                r_repeat_cnt <= '0;
            end else begin
                if (w_drop && !(&r_drop_cnt))
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                if (w_repeat && !(&r_repeat_cnt))
                    r_repeat_cnt <= r_repeat_cnt + CNT_W'(1);
            end
        end
    end

    assign drop_cnt   = r_drop_cnt;
    assign repeat_cnt = r_repeat_cnt;
`endif

endmodule

// File: tb/tb_vdma_baseaddr_arbiter.sv
// Self-checking bench for vdma_baseaddr_arbiter. Two instances (3 and 5
// buffers) share the same stimulus; a behavioural model predicts both.
module tb_vdma_baseaddr_arbiter;

    localparam int PTR_W = 3;
    localparam int CNT_W = 16;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b0;
    logic wr_vs  = 1'b0;
    logic rd_vs  = 1'b0;

    logic [PTR_W-1:0] wr_a, rd_a, wr_b, rd_b;
    logic             fresh_a, fresh_b, run_a, run_b;
`ifdef VDMA_BASEADDR_STAT_EN
    logic [CNT_W-1:0] drop_a, rep_a, drop_b, rep_b;
`endif

    always #5 clk = ~clk;

    vdma_baseaddr_arbiter #(.NUM_BUF(3), .PTR_W(PTR_W)
`ifdef VDMA_BASEADDR_STAT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_vs(wr_vs), .rd_vs(rd_vs),
        .wr_point(wr_a), .rd_point(rd_a), .frame_fresh(fresh_a), .run(run_a)
`ifdef VDMA_BASEADDR_STAT_EN
        , .drop_cnt(drop_a), .repeat_cnt(rep_a)
`endif
    );

    vdma_baseaddr_arbiter #(.NUM_BUF(5), .PTR_W(PTR_W)
`ifdef VDMA_BASEADDR_STAT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_vs(wr_vs), .rd_vs(rd_vs),
        .wr_point(wr_b), .rd_point(rd_b), .frame_fresh(fresh_b), .run(run_b)
`ifdef VDMA_BASEADDR_STAT_EN
        , .drop_cnt(drop_b), .repeat_cnt(rep_b)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    int nbuf[2] = '{3, 5};
    int m_mode[2];      // 0 = stopped, 1 = armed (waiting first write frame), 2 = running
    int m_wr[2];
    int m_rd[2];
    int m_latest[2];
    int m_fresh[2];
    int m_drop[2];
    int m_rep[2];
    bit m_pwv, m_prv, m_pen;

    function automatic int m_nf(input int x, input int a, input int n);
        for (int k = 1; k < n; k++)
            if ((x + k) % n != a) return (x + k) % n;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_wr[i] = 0; m_rd[i] = 1; m_latest[i] = 1;
            m_fresh[i] = 0; m_drop[i] = 0; m_rep[i] = 0;
        end
        m_pwv = 1'b0; m_prv = 1'b0; m_pen = 1'b0;
    endtask

    task automatic model_step();
        bit we, re, enr;
        int sat;
        sat = (1 << CNT_W) - 1;
        we  = wr_vs  && !m_pwv;
        re  = rd_vs  && !m_prv;
        enr = enable && !m_pen;
        for (int i = 0; i < 2; i++) begin
            if (enr) begin m_drop[i] = 0; m_rep[i] = 0; end
            if (m_mode[i] == 0) begin
                if (enable) m_mode[i] = 1;
            end else if (m_mode[i] == 1) begin
                if (!enable) m_mode[i] = 0;
                else if (we) m_mode[i] = 2;
            end else begin
                if (!enable) begin
                    m_mode[i] = 0; m_fresh[i] = 0;
                end else if (we && re) begin
                    m_rd[i] = m_wr[i]; m_latest[i] = m_wr[i];
                    m_wr[i] = (m_wr[i] + 1) % nbuf[i]; m_fresh[i] = 0;
                end else if (we) begin
                    if (m_fresh[i] != 0 && m_drop[i] < sat) m_drop[i]++;
                    m_latest[i] = m_wr[i];
                    m_wr[i] = m_nf(m_wr[i], m_rd[i], nbuf[i]);
                    m_fresh[i] = 1;
                end else if (re) begin
                    if (m_fresh[i] != 0) begin
                        m_rd[i] = m_latest[i]; m_fresh[i] = 0;
                    end else if (m_rep[i] < sat) m_rep[i]++;
                end
            end
        end
        m_pwv = wr_vs; m_prv = rd_vs; m_pen = enable;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_all();
        check("wr_point_a", 32'(wr_a), 32'(m_wr[0]));
        check("rd_point_a", 32'(rd_a), 32'(m_rd[0]));
        check("fresh_a",    32'(fresh_a), 32'(m_fresh[0]));
        check("run_a",      32'(run_a), 32'(m_mode[0] == 2));
        check("wr_point_b", 32'(wr_b), 32'(m_wr[1]));
        check("rd_point_b", 32'(rd_b), 32'(m_rd[1]));
        check("fresh_b",    32'(fresh_b), 32'(m_fresh[1]));
        check("run_b",      32'(run_b), 32'(m_mode[1] == 2));
        check("ptr_ok_b",   32'(wr_b != rd_b && wr_b < 3'd5 && rd_b < 3'd5), 1);
`ifdef VDMA_BASEADDR_STAT_EN
        check("drop_a",   32'(drop_a), 32'(m_drop[0]));
        check("repeat_a", 32'(rep_a),  32'(m_rep[0]));
        check("drop_b",   32'(drop_b), 32'(m_drop[1]));
        check("repeat_b", 32'(rep_b),  32'(m_rep[1]));
`endif
    endtask

    // One clock: drive at negedge, advance model at posedge, compare 1 ns later
    task automatic cycle(input bit en, input bit w, input bit r);
        @(negedge clk);
        enable = en; wr_vs = w; rd_vs = r;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        compare_all();
        $display("cyc en=%0b wv=%0b rv=%0b | A wr=%0d rd=%0d fr=%0b run=%0b | B wr=%0d rd=%0d fr=%0b run=%0b",
                 en, w, r, wr_a, rd_a, fresh_a, run_a, wr_b, rd_b, fresh_b, run_b);
    endtask

    task automatic pulse(input bit en, input bit w, input bit r);
        cycle(en, w, r);
        cycle(en, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        check("rst_wr",    32'(wr_a), 0);
        check("rst_rd",    32'(rd_a), 1);
        check("rst_fresh", 32'(fresh_a), 0);
        check("rst_run",   32'(run_a), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start-up: arm, then first write frame starts RUN without moving pointers
        cycle(1'b1, 1'b0, 1'b0);
        check("prime_run", 32'(run_a), 0);
        pulse(1'b1, 1'b1, 1'b0);
        check("t1_run", 32'(run_a), 1);
        check("t1_wr",  32'(wr_a), 0);
        check("t1_rd",  32'(rd_a), 1);

        // Two write frames, then a read
        pulse(1'b1, 1'b1, 1'b0);
        check("t2_wr1",    32'(wr_a), 2);
        check("t2_fresh1", 32'(fresh_a), 1);
        pulse(1'b1, 1'b1, 1'b0);
        check("t2_wr2",    32'(wr_a), 0);
        check("t2_fresh2", 32'(fresh_a), 1);
`ifdef VDMA_BASEADDR_STAT_EN
        check("t3_drop", 32'(drop_a), 1);
`endif
        pulse(1'b1, 1'b0, 1'b1);
        check("t2_rd",     32'(rd_a), 2);
        check("t2_fresh3", 32'(fresh_a), 0);
        pulse(1'b1, 1'b0, 1'b1);
        check("t3_rd_hold", 32'(rd_a), 2);
`ifdef VDMA_BASEADDR_STAT_EN
        check("t3_repeat", 32'(rep_a), 1);
`endif

        // Walk to wr=2, rd=0, then simultaneous edges
        pulse(1'b1, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        pulse(1'b1, 1'b1, 1'b0);
        check("t4_pre_wr", 32'(wr_a), 2);
        check("t4_pre_rd", 32'(rd_a), 0);
        pulse(1'b1, 1'b1, 1'b1);
        check("t4_rd",    32'(rd_a), 2);
        check("t4_wr",    32'(wr_a), 0);
        check("t4_fresh", 32'(fresh_a), 0);

        // Disable from RUN clears freshness, edges then ignored
        pulse(1'b1, 1'b1, 1'b0);
        check("dis_pre_fresh", 32'(fresh_a), 1);
        cycle(1'b0, 1'b0, 1'b0);
        check("dis_run",   32'(run_a), 0);
        check("dis_fresh", 32'(fresh_a), 0);
        pulse(1'b0, 1'b1, 1'b1);
        check("dis_wr", 32'(wr_a), 1);
        check("dis_rd", 32'(rd_a), 2);
        cycle(1'b1, 1'b0, 1'b0);
`ifdef VDMA_BASEADDR_STAT_EN
        check("clr_drop",   32'(drop_a), 0);
        check("clr_repeat", 32'(rep_a), 0);
`endif
        pulse(1'b1, 1'b0, 1'b1);
        check("prime_rd_ign", 32'(rd_a), 2);
        pulse(1'b1, 1'b1, 1'b0);
        check("rerun_run", 32'(run_a), 1);
        check("rerun_wr",  32'(wr_a), 1);

        // Random vsync levels (occasional disable)
        for (int n = 0; n < 2000; n++)
            cycle(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Asynchronous reset mid-frame
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("arst_wr",    32'(wr_a), 0);
        check("arst_rd",    32'(rd_a), 1);
        check("arst_fresh", 32'(fresh_a), 0);
        check("arst_run",   32'(run_a), 0);
        cycle(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        pulse(1'b0, 1'b1, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        check("idle_wr",  32'(wr_a), 0);
        check("idle_rd",  32'(rd_a), 1);
        check("idle_run", 32'(run_a), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
